// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for seq_alu. Holds the one-hot op bit
//                indices, the FSM state type and the latency helpers. The
//                multiply latency depends on SEQ_ALU_MUL_RADIX4_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int SIG_COUNT = 12;

    // Bit positions inside the one-hot ctrl vector
    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_MUL = 2;
    localparam int OP_DIV = 3;
    localparam int OP_SHR = 4;
    localparam int OP_SHL = 5;
    localparam int OP_ROR = 6;
    localparam int OP_ROL = 7;
    localparam int OP_AND = 8;
    localparam int OP_OR  = 9;
    localparam int OP_NEG = 10;
    localparam int OP_NOT = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_IT  = 2'd1,
        ST_DIV_IT  = 2'd2,
        ST_DIV_FIX = 2'd3
    } state_t;

    // Number of Booth recode steps for a given operand width
    function automatic int mul_iters(input int bits);
`ifdef SEQ_ALU_MUL_RADIX4_EN
        return bits / 2;
`else
        return bits;
`endif
    endfunction

    // Edges from the start-sampling edge to the done edge
    function automatic int mul_lat(input int bits);
        return mul_iters(bits) + 1;
    endfunction

    function automatic int div_lat(input int bits);
        return bits + 2;
    endfunction

    localparam int DEFAULT_BITS = 32;
    localparam int MUL_LAT      = mul_lat(DEFAULT_BITS);
    localparam int DIV_LAT      = div_lat(DEFAULT_BITS);

endpackage
`default_nettype wire

// File: rtl/alu_iter_div.sv
`default_nettype none
// ============================================================================
//  Module      : alu_iter_div
//  Description : Iterative non-restoring signed divider core. load captures
//                operand magnitudes and signs, step performs one iteration,
//                fix commits the final remainder restore. quotient/remainder
//                present the sign-corrected results (truncating division,
//                remainder carries the dividend's sign).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_iter_div #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            load,
    input  logic            step,
    input  logic            fix,
    input  logic [BITS-1:0] dividend,
    input  logic [BITS-1:0] divisor,
    output logic [BITS-1:0] quotient,
    output logic [BITS-1:0] remainder
);
    import alu_pkg::*;

    // Two guard bits: partial remainder lies in [-d, d) and 2r needs one more
    localparam int RW = BITS + 2;

    logic [RW-1:0]   rem_r;
    logic [BITS-1:0] quo_r;
    logic [BITS-1:0] dsr_r;
    logic            neg_q;
    logic            neg_r;

    logic [BITS-1:0] dvd_mag;
    logic [BITS-1:0] dsr_mag;
    logic [RW-1:0]   dsr_ext;
    logic [RW-1:0]   rem_shift;
    logic [RW-1:0]   rem_step;
    logic [RW-1:0]   rem_rest;

    // Magnitudes, one iteration and the final restore/sign fix-up
    always_comb begin
        dvd_mag   = dividend[BITS-1] ? ('0 - dividend) : dividend;
        dsr_mag   = divisor[BITS-1]  ? ('0 - divisor)  : divisor;
        dsr_ext   = {2'b00, dsr_r};
        rem_shift = {rem_r[RW-2:0], quo_r[BITS-1]};
        rem_step  = rem_r[RW-1] ? (rem_shift + dsr_ext) : (rem_shift - dsr_ext);
        rem_rest  = rem_r[RW-1] ? (rem_r + dsr_ext) : rem_r;
        quotient  = neg_q ? ('0 - quo_r) : quo_r;
        remainder = neg_r ? ('0 - rem_rest[BITS-1:0]) : rem_rest[BITS-1:0];
    end

    // Divider state: quo_r shifts dividend bits out and quotient bits in
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rem_r <= '0;
            quo_r <= '0;
            dsr_r <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (load) begin
            rem_r <= '0;
            quo_r <= dvd_mag;
            dsr_r <= dsr_mag;
            neg_q <= dividend[BITS-1] ^ divisor[BITS-1];
            neg_r <= dividend[BITS-1];
        end else if (step) begin
            rem_r <= rem_step;
            quo_r <= {quo_r[BITS-2:0], ~rem_step[RW-1]};
        end else if (fix) begin
            rem_r <= rem_rest;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Multi-cycle ALU with start/busy/done handshake. Single-cycle
//                logic/arith ops, iterative Booth multiplier (inline) and
//                iterative non-restoring divider (alu_iter_div).
//                Define SEQ_ALU_MUL_RADIX4_EN for a radix-4 Booth multiplier
//                (BITS/2 iterations); default is radix-2 (BITS iterations).
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int BITS      = 32,
    parameter int SIG_COUNT = 12
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [SIG_COUNT-1:0] ctrl,
    input  logic [BITS-1:0]      x,
    input  logic [BITS-1:0]      y,
    output logic [2*BITS-1:0]    result,
    output logic                 busy,
    output logic                 done,
    output logic                 div0,
    output logic                 illegal
);
    import alu_pkg::*;

    localparam int SH_W      = $clog2(BITS);
    localparam int CNT_W     = $clog2(BITS);
    localparam int AW        = BITS + 2;
    localparam int MUL_ITERS = mul_lat(BITS) - 1;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;

    logic              accept;
    logic              legal;
    logic              y_zero;
    logic              mul_go;
    logic              div_go;
    logic              mul_step;
    logic              mul_last;
    logic              div_step;
    logic              div_fix;

    logic [SH_W-1:0]   sh;
    logic [BITS-1:0]   lo_single;

    logic [AW-1:0]     mul_a;
    logic [BITS-1:0]   mul_q;
    logic              mul_qm1;
    logic [BITS-1:0]   mul_m;
    logic [AW-1:0]     m_ext;
    logic [AW-1:0]     mul_sum;
    logic [AW-1:0]     mul_a_n;
    logic [BITS-1:0]   mul_q_n;
    logic              mul_qm1_n;
    logic [2*BITS-1:0] mul_product;

    logic [BITS-1:0]   div_quo;
    logic [BITS-1:0]   div_rem;

    // Request decode: acceptance, one-hot legality and which engine to start
    always_comb begin
        accept = start && (state == ST_IDLE);
        legal  = (ctrl != '0) && ((ctrl & (ctrl - SIG_COUNT'(1))) == '0);
        y_zero = (y == '0);
        mul_go = accept && legal && ctrl[OP_MUL];
        div_go = accept && legal && ctrl[OP_DIV] && !y_zero;
    end

    // FSM state register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (mul_go) begin
                    state_nxt = ST_MUL_IT;
                end else if (div_go) begin
                    state_nxt = ST_DIV_IT;
                end
            end
            ST_MUL_IT:  if (cnt == '0) state_nxt = ST_IDLE;
            ST_DIV_IT:  if (cnt == '0) state_nxt = ST_DIV_FIX;
            ST_DIV_FIX: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: engine strobes and busy
    always_comb begin
        busy     = (state != ST_IDLE);
        mul_step = (state == ST_MUL_IT);
        mul_last = (state == ST_MUL_IT) && (cnt == '0);
        div_step = (state == ST_DIV_IT);
        div_fix  = (state == ST_DIV_FIX);
    end

    // Iteration counter: loaded with iterations-1, counts down to the last step
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt <= '0;
        end else if (mul_go) begin
            cnt <= CNT_W'(MUL_ITERS - 1);
        end else if (div_go) begin
            cnt <= CNT_W'(BITS - 1);
        end else if ((mul_step || div_step) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Single-cycle ops; upper bits of y are ignored for shift amounts
    always_comb begin
        sh        = y[SH_W-1:0];
        lo_single = '0;
        if (ctrl[OP_ADD])      lo_single = x + y;
        else if (ctrl[OP_SUB]) lo_single = x - y;
        else if (ctrl[OP_SHR]) lo_single = x >> sh;
        else if (ctrl[OP_SHL]) lo_single = x << sh;
        else if (ctrl[OP_ROR]) lo_single = (x >> sh) | (x << (BITS - int'(sh)));
        else if (ctrl[OP_ROL]) lo_single = (x << sh) | (x >> (BITS - int'(sh)));
        else if (ctrl[OP_AND]) lo_single = x & y;
        else if (ctrl[OP_OR])  lo_single = x | y;
        else if (ctrl[OP_NEG]) lo_single = '0 - y;
        else if (ctrl[OP_NOT]) lo_single = ~y;
    end

    // Booth recode step; A carries two guard bits so +/-2M never overflows
    always_comb begin
        m_ext = {{2{mul_m[BITS-1]}}, mul_m};
`ifdef SEQ_ALU_MUL_RADIX4_EN
        case ({mul_q[1:0], mul_qm1})
            3'b001, 3'b010: mul_sum = mul_a + m_ext;
            3'b011:         mul_sum = mul_a + (m_ext << 1);
            3'b100:         mul_sum = mul_a - (m_ext << 1);
            3'b101, 3'b110: mul_sum = mul_a - m_ext;
            default:        mul_sum = mul_a;
        endcase
        mul_a_n   = {{2{mul_sum[AW-1]}}, mul_sum[AW-1:2]};
        mul_q_n   = {mul_sum[1:0], mul_q[BITS-1:2]};
        mul_qm1_n = mul_q[1];
`else
        case ({mul_q[0], mul_qm1})
            2'b01:   mul_sum = mul_a + m_ext;
            2'b10:   mul_sum = mul_a - m_ext;
            default: mul_sum = mul_a;
        endcase
        mul_a_n   = {mul_sum[AW-1], mul_sum[AW-1:1]};
        mul_q_n   = {mul_sum[0], mul_q[BITS-1:1]};
        mul_qm1_n = mul_q[0];
`endif
        mul_product = {mul_a_n[BITS-1:0], mul_q_n};
    end

    // Multiplier registers: M = x, {A,Q,q-1} shifts right each step
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mul_a   <= '0;
            mul_q   <= '0;
            mul_qm1 <= 1'b0;
            mul_m   <= '0;
        end else if (mul_go) begin
            mul_a   <= '0;
            mul_q   <= y;
            mul_qm1 <= 1'b0;
            mul_m   <= x;
        end else if (mul_step) begin
            mul_a   <= mul_a_n;
            mul_q   <= mul_q_n;
            mul_qm1 <= mul_qm1_n;
        end
    end

    alu_iter_div #(
        .BITS (BITS)
    ) u_div (
        .clk       (clk),
        .clr       (clr),
        .load      (div_go),
        .step      (div_step),
        .fix       (div_fix),
        .dividend  (x),
        .divisor   (y),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Result, done pulse and status flags; flags change only on accepted starts
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            result  <= '0;
            done    <= 1'b0;
            div0    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                div0    <= legal && ctrl[OP_DIV] && y_zero;
                illegal <= !legal;
                if (!legal) begin
                    done <= 1'b1;
                end else if (ctrl[OP_DIV] && y_zero) begin
                    result <= {x, {BITS{1'b1}}};
                    done   <= 1'b1;
                end else if (!ctrl[OP_MUL] && !ctrl[OP_DIV]) begin
                    result <= {{BITS{1'b0}}, lo_single};
                    done   <= 1'b1;
                end
            end else if (mul_last) begin
                result <= mul_product;
                done   <= 1'b1;
            end else if (div_fix) begin
                result <= {div_rem, div_quo};
                done   <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu
//  Description : Self-checking bench for seq_alu (BITS=32). Directed cases
//                plus randomized ops against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    localparam int W = 32;
`ifdef SEQ_ALU_MUL_RADIX4_EN
    localparam int MUL_CYC = W / 2 + 1;
`else
    localparam int MUL_CYC = W + 1;
`endif
    localparam int DIV_CYC = W + 2;

    logic           clk = 1'b0;
    logic           clr = 1'b0;
    logic           start = 1'b0;
    logic [11:0]    ctrl = '0;
    logic [W-1:0]   x = '0;
    logic [W-1:0]   y = '0;
    logic [2*W-1:0] result;
    logic           busy;
    logic           done;
    logic           div0;
    logic           illegal;

    int             n_tests = 0;
    int             n_fail  = 0;
    logic [63:0]    last_res = '0;

    always #5 clk = ~clk;

    seq_alu #(
        .BITS      (W),
        .SIG_COUNT (12)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .start   (start),
        .ctrl    (ctrl),
        .x       (x),
        .y       (y),
        .result  (result),
        .busy    (busy),
        .done    (done),
        .div0    (div0),
        .illegal (illegal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands
    function automatic logic [63:0] model(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        int          sh;
        logic [W-1:0] lo;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        lo = '0;
        case (op)
            0: lo = a + b;
            1: lo = a - b;
            2: return 64'(sa * sb);
            3: begin
                if (b == '0) return {a, {W{1'b1}}};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4: lo = a >> sh;
            5: lo = a << sh;
            6: begin
                lo = a;
                for (int i = 0; i < sh; i++) lo = {lo[0], lo[W-1:1]};
            end
            7: begin
                lo = a;
                for (int i = 0; i < sh; i++) lo = {lo[W-2:0], lo[W-1]};
            end
            8:  lo = a & b;
            9:  lo = a | b;
            10: lo = -b;
            11: lo = ~b;
            default: lo = '0;
        endcase
        return {32'h0, lo};
    endfunction

    // Issue one op, wait for done, compare latency, busy span, result, flags
    task automatic run_op(input logic [11:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit b2b, input int glitch, input string tag);
        int          op;
        int          lat;
        int          cyc;
        int          busy_n;
        logic [63:0] exp_res;
        logic        exp_div0;
        logic        exp_ill;
        op = -1;
        for (int i = 0; i < 12; i++) if (ctl[i]) op = i;
        if ($countones(ctl) != 1) begin
            exp_res  = last_res;
            exp_ill  = 1'b1;
            exp_div0 = 1'b0;
            lat      = 1;
        end else begin
            exp_res  = model(op, a, b);
            exp_ill  = 1'b0;
            exp_div0 = (op == 3) && (b == '0);
            lat      = (op == 2) ? MUL_CYC : ((op == 3) && (b != '0)) ? DIV_CYC : 1;
        end
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        ctrl  = ctl;
        x     = a;
        y     = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        ctrl   = 12'($urandom);
        x      = $urandom;
        y      = $urandom;
        cyc    = 1;
        busy_n = 0;
        while (!done && cyc < 100) begin
            if (busy) busy_n++;
            start = (cyc == glitch);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check($sformatf("%s latency", tag), 64'(cyc), 64'(lat));
        check($sformatf("%s busy_cycles", tag), 64'(busy_n), 64'(lat - 1));
        check($sformatf("%s busy_at_done", tag), {63'd0, busy}, 64'd0);
        check($sformatf("%s result", tag), result, exp_res);
        check($sformatf("%s div0", tag), {63'd0, div0}, {63'd0, exp_div0});
        check($sformatf("%s illegal", tag), {63'd0, illegal}, {63'd0, exp_ill});
        last_res = exp_res;
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s result", tag), result, 64'd0);
        check($sformatf("%s busy", tag), {63'd0, busy}, 64'd0);
        check($sformatf("%s done", tag), {63'd0, done}, 64'd0);
        check($sformatf("%s div0", tag), {63'd0, div0}, 64'd0);
        check($sformatf("%s illegal", tag), {63'd0, illegal}, 64'd0);
    endtask

    int pa[4] = '{15, -15, 15, -15};
    int pb[4] = '{5, 5, -5, -5};

    initial begin
        logic [11:0]  ctl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           k;
        int           j;
        int           seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        clr = 1'b1;

        // Single-cycle ops over the four sign combinations
        for (int op = 0; op < 12; op++) begin
            if (op == 2 || op == 3) continue;
            for (int p = 0; p < 4; p++)
                run_op(12'b1 << op, W'(pa[p]), W'(pb[p]), 1'b0, -1, $sformatf("op%0d p%0d", op, p));
        end
        @(posedge clk);
        #1;
        check("done_one_cycle", {63'd0, done}, 64'd0);

        // Multiply and divide over the same pairs
        for (int p = 0; p < 4; p++)
            run_op(12'b1 << 2, W'(pa[p]), W'(pb[p]), 1'b0, -1, $sformatf("mul p%0d", p));
        for (int p = 0; p < 4; p++)
            run_op(12'b1 << 3, W'(pa[p]), W'(pb[p]), 1'b0, -1, $sformatf("div p%0d", p));
        run_op(12'b1 << 3, 32'd17, -32'sd5, 1'b0, -1, "div 17/-5");
        run_op(12'b1 << 3, -32'sd17, 32'd5, 1'b0, -1, "div -17/5");
        run_op(12'b1 << 3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, "div minneg/-1");
        @(posedge clk);
        #1;
        check("done_one_cycle_div", {63'd0, done}, 64'd0);

        // Divide by zero, then a normal op clears the flag
        run_op(12'b1 << 3, 32'd15, 32'd0, 1'b0, -1, "div0");
        run_op(12'b1 << 0, 32'd3, 32'd5, 1'b0, -1, "add after div0");

        // Illegal ctrl leaves result unchanged
        run_op(12'b0000_0000_0011, 32'd1, 32'd2, 1'b0, -1, "illegal multi");
        run_op(12'b0, 32'd1, 32'd2, 1'b0, -1, "illegal zero");

        // start while busy is ignored
        run_op(12'b1 << 2, 32'd15, 32'd5, 1'b0, 5, "mul glitch");

        // Back-to-back starts in the done cycle
        run_op(12'b1 << 2, -32'sd7, 32'd9, 1'b0, -1, "b2b mul");
        run_op(12'b1 << 1, 32'd100, 32'd1, 1'b1, -1, "b2b sub");
        run_op(12'b1 << 3, 32'd100, 32'd7, 1'b1, -1, "b2b div");
        run_op(12'b1 << 6, 32'h1234_5678, 32'd4, 1'b1, -1, "b2b ror");

        // Randomized ops
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 13);
            if (k < 12) begin
                ctl = 12'b1 << k;
            end else if (k == 12) begin
                ctl = '0;
            end else begin
                j   = $urandom_range(0, 11);
                ctl = (12'b1 << j) | (12'b1 << ((j + 1 + $urandom_range(0, 10)) % 12));
            end
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = W'($urandom_range(0, 40)) - 32'd20;
            if ($urandom_range(0, 3) == 0) b = W'($urandom_range(0, 40)) - 32'd20;
            if ($urandom_range(0, 7) == 0) b = '0;
            run_op(ctl, a, b, 1'($urandom_range(0, 1)), -1, $sformatf("rnd%0d", n));
        end

        // Reset in the middle of a divide
        run_op(12'b1 << 0, 32'd3, 32'd5, 1'b0, -1, "pre-clr add");
        @(posedge clk);
        #1;
        start = 1'b1;
        ctrl  = 12'b1 << 3;
        x     = 32'd100;
        y     = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        clr = 1'b0;
        #1;
        check_reset_outputs("mid-div clr");
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr  = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("no done after clr", 64'(seen), 64'd0);
        last_res = '0;
        run_op(12'b1 << 2, 32'd15, 32'd5, 1'b0, -1, "mul after clr");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
